// File: rtl/lsu_pkg.sv
// Shared LSU definitions: RV32 funct3 codes, FSM states, byte-enable bases
// and the legality/lane helpers used when an op is accepted.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  typedef struct packed {
    logic       load;
    logic [2:0] f3;
    logic [1:0] lo;
    logic [4:0] rd;
  } lsu_op_t;

  // Unsigned variants exist only for loads; alignment follows access size.
  function automatic logic op_legal(input logic load, input logic [2:0] f3,
                                    input logic [1:0] lo);
    case (f3)
      F3_B:    return 1'b1;
      F3_BU:   return load;
      F3_H:    return ~lo[0];
      F3_HU:   return load & ~lo[0];
      F3_W:    return lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] op_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return BE_B << lo;
      2'b01:   return BE_H << lo;
      default: return BE_W;
    endcase
  endfunction

  function automatic logic [31:0] op_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction
endpackage

// File: rtl/lsu_if.sv
// Data-memory port: single outstanding req/gnt/rvalid transaction.
interface lsu_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic                mem_req_w_o_h;
  logic                mem_we_w_o_h;
  logic [ADDR_W-1:0]   mem_addr_w_o;
  logic [DATA_W/8-1:0] mem_be_w_o;
  logic [DATA_W-1:0]   mem_wdata_w_o;
  logic                mem_gnt_w_i_h;
  logic                mem_rvalid_w_i_h;
  logic [DATA_W-1:0]   mem_rdata_w_i;

  modport master(output mem_req_w_o_h, mem_we_w_o_h, mem_addr_w_o, mem_be_w_o,
                 mem_wdata_w_o,
                 input  mem_gnt_w_i_h, mem_rvalid_w_i_h, mem_rdata_w_i);
  modport slave (input  mem_req_w_o_h, mem_we_w_o_h, mem_addr_w_o, mem_be_w_o,
                 mem_wdata_w_o,
                 output mem_gnt_w_i_h, mem_rvalid_w_i_h, mem_rdata_w_i);
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{addr_lo, 3'b000} +: 8];
    h    = rdata[{addr_lo[1], 4'b0000} +: 16];
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'b0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'b0, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// RV32 load/store unit: accepts one op from execute, runs a single memory
// transaction and returns a one-cycle response. All outputs are flops.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_w_i,
  input  logic              rst_w_i_l,
  input  logic              req_valid_w_i_h,
  output logic              req_ready_w_o_h,
  input  logic              load_w_i_h,
  input  logic [2:0]        funct3_w_i,
  input  logic [ADDR_W-1:0] addr_w_i,
  input  logic [DATA_W-1:0] store_data_w_i,
  input  logic [4:0]        rd_w_i,
  lsu_if.master             mem,
  output logic              resp_valid_w_o_h,
  output logic [DATA_W-1:0] resp_data_w_o,
  output logic [4:0]        resp_rd_w_o,
  output logic              resp_err_w_o_h,
  output logic              busy_w_o_h
);
  state_e      state, state_nxt;
  lsu_op_t     op_q;
  logic        accept, legal;
  logic [31:0] ld_data;

  assign accept = (state == S_IDLE) && req_valid_w_i_h;
  assign legal  = op_legal(load_w_i_h, funct3_w_i, addr_w_i[1:0]);

  lsu_load_align u_align (
    .rdata   (mem.mem_rdata_w_i),
    .addr_lo (op_q.lo),
    .funct3  (op_q.f3),
    .data    (ld_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid_w_i_h) state_nxt = legal ? S_REQ : S_RESP;
      S_REQ:   if (mem.mem_gnt_w_i_h) state_nxt = op_q.load ? S_WAIT : S_RESP;
      S_WAIT:  if (mem.mem_rvalid_w_i_h) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered off state_nxt so they line up with the state flop.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      state             <= S_IDLE;
      op_q              <= '0;
      req_ready_w_o_h   <= 1'b1;
      busy_w_o_h        <= 1'b0;
      resp_valid_w_o_h  <= 1'b0;
      resp_data_w_o     <= '0;
      resp_rd_w_o       <= '0;
      resp_err_w_o_h    <= 1'b0;
      mem.mem_req_w_o_h <= 1'b0;
      mem.mem_we_w_o_h  <= 1'b0;
      mem.mem_addr_w_o  <= '0;
      mem.mem_be_w_o    <= '0;
      mem.mem_wdata_w_o <= '0;
    end else begin
      state             <= state_nxt;
      req_ready_w_o_h   <= state_nxt == S_IDLE;
      busy_w_o_h        <= state_nxt != S_IDLE;
      resp_valid_w_o_h  <= state_nxt == S_RESP;
      mem.mem_req_w_o_h <= state_nxt == S_REQ;
      mem.mem_we_w_o_h  <= (state_nxt == S_REQ) & (accept ? ~load_w_i_h : ~op_q.load);
      if (accept) begin
        op_q              <= '{load: load_w_i_h, f3: funct3_w_i, lo: addr_w_i[1:0], rd: rd_w_i};
        mem.mem_addr_w_o  <= {addr_w_i[ADDR_W-1:2], 2'b00};
        mem.mem_be_w_o    <= op_be(funct3_w_i, addr_w_i[1:0]);
        mem.mem_wdata_w_o <= op_wdata(funct3_w_i, store_data_w_i);
      end
      // Response fields only move on entry to RESP and hold afterwards.
      if (state_nxt == S_RESP) begin
        resp_rd_w_o    <= (state == S_IDLE) ? rd_w_i : op_q.rd;
        resp_err_w_o_h <= state == S_IDLE;
        resp_data_w_o  <= (state == S_WAIT) ? ld_data : '0;
      end
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed vectors, one task per scenario.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk_w_i = 1'b0;
  logic        rst_w_i_l = 1'b0;
  logic        req_valid_w_i_h = 1'b0;
  logic        req_ready_w_o_h;
  logic        load_w_i_h = 1'b0;
  logic [2:0]  funct3_w_i = '0;
  logic [31:0] addr_w_i = '0;
  logic [31:0] store_data_w_i = '0;
  logic [4:0]  rd_w_i = '0;
  logic        resp_valid_w_o_h;
  logic [31:0] resp_data_w_o;
  logic [4:0]  resp_rd_w_o;
  logic        resp_err_w_o_h;
  logic        busy_w_o_h;

  int checks = 0;
  int errors = 0;
  logic [127:0] obs, exp;

  lsu_if m_if ();

  lsu dut (
    .clk_w_i          (clk_w_i),
    .rst_w_i_l        (rst_w_i_l),
    .req_valid_w_i_h  (req_valid_w_i_h),
    .req_ready_w_o_h  (req_ready_w_o_h),
    .load_w_i_h       (load_w_i_h),
    .funct3_w_i       (funct3_w_i),
    .addr_w_i         (addr_w_i),
    .store_data_w_i   (store_data_w_i),
    .rd_w_i           (rd_w_i),
    .mem              (m_if),
    .resp_valid_w_o_h (resp_valid_w_o_h),
    .resp_data_w_o    (resp_data_w_o),
    .resp_rd_w_o      (resp_rd_w_o),
    .resp_err_w_o_h   (resp_err_w_o_h),
    .busy_w_o_h       (busy_w_o_h)
  );

  // Reference extractor, checked standalone against hand values.
  logic [31:0] ref_rdata = '0, ref_data;
  logic [1:0]  ref_lo = '0;
  logic [2:0]  ref_f3 = '0;
  lsu_load_align u_ref (.rdata(ref_rdata), .addr_lo(ref_lo), .funct3(ref_f3), .data(ref_data));

  always #5 clk_w_i = ~clk_w_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_w_i);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
    req_valid_w_i_h = 1'b1;
    load_w_i_h = ld; funct3_w_i = f3; addr_w_i = a; store_data_w_i = d; rd_w_i = rd;
  endtask

  task automatic test_reset();
    m_if.mem_gnt_w_i_h = 1'b0; m_if.mem_rvalid_w_i_h = 1'b0; m_if.mem_rdata_w_i = '0;
    #12;
    obs = {req_ready_w_o_h, busy_w_o_h, m_if.mem_req_w_o_h, m_if.mem_we_w_o_h,
           resp_valid_w_o_h, resp_err_w_o_h, resp_rd_w_o, m_if.mem_be_w_o};
    exp = {6'b100000, 5'd0, 4'd0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset_ctrl: got %h exp %h", obs, exp); end
    obs = {m_if.mem_addr_w_o, m_if.mem_wdata_w_o, resp_data_w_o};
    exp = '0;
    checks++; if (obs !== exp) begin errors++; $display("FAIL reset_data: got %h exp %h", obs, exp); end
    rst_w_i_l = 1'b1;
    tick();
  endtask

  task automatic test_align();
    ref_rdata = 32'h80FF_1234; ref_lo = 2'd3; ref_f3 = F3_B; #1;
    checks++; if (ref_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL align_lb: got %h exp %h", ref_data, 32'hFFFF_FF80); end
    ref_rdata = 32'h1234_8000; ref_lo = 2'd0; ref_f3 = F3_H; #1;
    checks++; if (ref_data !== 32'hFFFF_8000) begin errors++; $display("FAIL align_lh: got %h exp %h", ref_data, 32'hFFFF_8000); end
    ref_rdata = 32'h1234_5678; ref_lo = 2'd1; ref_f3 = F3_BU; #1;
    checks++; if (ref_data !== 32'h0000_0056) begin errors++; $display("FAIL align_lbu: got %h exp %h", ref_data, 32'h0000_0056); end
  endtask

  task automatic test_lb();
    set_op(1'b1, F3_B, 32'h1003, 32'h0, 5'd5);
    tick();
    req_valid_w_i_h = 1'b0;
    obs = {req_ready_w_o_h, busy_w_o_h, m_if.mem_req_w_o_h, m_if.mem_we_w_o_h, m_if.mem_be_w_o, m_if.mem_addr_w_o};
    exp = {4'b0110, 4'b1000, 32'h1000};
    checks++; if (obs !== exp) begin errors++; $display("FAIL lb_req: got %h exp %h", obs, exp); end
    m_if.mem_gnt_w_i_h = 1'b1;
    tick();
    m_if.mem_gnt_w_i_h = 1'b0;
    obs = {m_if.mem_req_w_o_h, resp_valid_w_o_h, busy_w_o_h};
    exp = 3'b001;
    checks++; if (obs !== exp) begin errors++; $display("FAIL lb_wait: got %h exp %h", obs, exp); end
    m_if.mem_rvalid_w_i_h = 1'b1; m_if.mem_rdata_w_i = 32'h80FF_1234;
    tick();
    m_if.mem_rvalid_w_i_h = 1'b0;
    obs = {resp_valid_w_o_h, resp_err_w_o_h, req_ready_w_o_h, resp_rd_w_o, resp_data_w_o};
    exp = {3'b100, 5'd5, 32'hFFFF_FF80};
    checks++; if (obs !== exp) begin errors++; $display("FAIL lb_resp: got %h exp %h", obs, exp); end
    tick();
    obs = {resp_valid_w_o_h, req_ready_w_o_h, busy_w_o_h, resp_data_w_o};
    exp = {3'b010, 32'hFFFF_FF80};
    checks++; if (obs !== exp) begin errors++; $display("FAIL lb_idle: got %h exp %h", obs, exp); end
  endtask

  task automatic test_lhu();
    set_op(1'b1, F3_HU, 32'h2002, 32'h0, 5'd7);
    tick();
    req_valid_w_i_h = 1'b0;
    obs = {m_if.mem_req_w_o_h, m_if.mem_be_w_o, m_if.mem_addr_w_o};
    exp = {1'b1, 4'b1100, 32'h2000};
    checks++; if (obs !== exp) begin errors++; $display("FAIL lhu_req: got %h exp %h", obs, exp); end
    m_if.mem_gnt_w_i_h = 1'b1;
    tick();
    m_if.mem_gnt_w_i_h = 1'b0; m_if.mem_rvalid_w_i_h = 1'b1; m_if.mem_rdata_w_i = 32'hBEEF_0000;
    tick();
    m_if.mem_rvalid_w_i_h = 1'b0;
    obs = {resp_valid_w_o_h, resp_err_w_o_h, resp_rd_w_o, resp_data_w_o};
    exp = {2'b10, 5'd7, 32'h0000_BEEF};
    checks++; if (obs !== exp) begin errors++; $display("FAIL lhu_resp: got %h exp %h", obs, exp); end
    tick();
  endtask

  task automatic test_stray();
    m_if.mem_gnt_w_i_h = 1'b1; m_if.mem_rvalid_w_i_h = 1'b1;
    tick();
    tick();
    m_if.mem_gnt_w_i_h = 1'b0; m_if.mem_rvalid_w_i_h = 1'b0;
    obs = {req_ready_w_o_h, busy_w_o_h, m_if.mem_req_w_o_h, resp_valid_w_o_h};
    exp = 4'b1000;
    checks++; if (obs !== exp) begin errors++; $display("FAIL stray: got %h exp %h", obs, exp); end
  endtask

  task automatic test_sb_stall();
    set_op(1'b0, F3_B, 32'h0001, 32'h1234_56AB, 5'd3);
    tick();
    req_valid_w_i_h = 1'b0;
    store_data_w_i = 32'hFFFF_FFFF; addr_w_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      obs = {resp_valid_w_o_h, m_if.mem_req_w_o_h, m_if.mem_we_w_o_h, m_if.mem_be_w_o,
             m_if.mem_addr_w_o, m_if.mem_wdata_w_o};
      exp = {3'b011, 4'b0010, 32'h0, 32'hABAB_ABAB};
      checks++; if (obs !== exp) begin errors++; $display("FAIL sb_stall%0d: got %h exp %h", i, obs, exp); end
      if (i < 3) tick();
    end
    m_if.mem_gnt_w_i_h = 1'b1;
    tick();
    m_if.mem_gnt_w_i_h = 1'b0;
    obs = {resp_valid_w_o_h, resp_err_w_o_h, m_if.mem_req_w_o_h, resp_rd_w_o, resp_data_w_o};
    exp = {3'b100, 5'd3, 32'h0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL sb_resp: got %h exp %h", obs, exp); end
    tick();
    checks++; if (resp_valid_w_o_h !== 1'b0) begin errors++; $display("FAIL sb_pulse: got %b exp 0", resp_valid_w_o_h); end
  endtask

  task automatic test_err();
    m_if.mem_rdata_w_i = 32'hFFFF_FFFF;
    set_op(1'b1, F3_W, 32'h0002, 32'h0, 5'd9);
    tick();
    req_valid_w_i_h = 1'b0;
    obs = {resp_valid_w_o_h, resp_err_w_o_h, m_if.mem_req_w_o_h, resp_rd_w_o, resp_data_w_o};
    exp = {3'b110, 5'd9, 32'h0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL err_misalign: got %h exp %h", obs, exp); end
    tick();
    obs = {resp_valid_w_o_h, req_ready_w_o_h, m_if.mem_req_w_o_h};
    exp = 3'b010;
    checks++; if (obs !== exp) begin errors++; $display("FAIL err_idle: got %h exp %h", obs, exp); end
    set_op(1'b1, 3'b011, 32'h0000, 32'h0, 5'd10);
    tick();
    req_valid_w_i_h = 1'b0;
    obs = {resp_valid_w_o_h, resp_err_w_o_h, m_if.mem_req_w_o_h, resp_rd_w_o, resp_data_w_o};
    exp = {3'b110, 5'd10, 32'h0};
    checks++; if (obs !== exp) begin errors++; $display("FAIL err_funct3: got %h exp %h", obs, exp); end
    tick();
  endtask

  task automatic test_back_to_back();
    set_op(1'b1, F3_W, 32'h0100, 32'h0, 5'd1);
    tick();
    set_op(1'b1, F3_BU, 32'h0101, 32'h0, 5'd2);
    obs = {req_ready_w_o_h, m_if.mem_req_w_o_h, m_if.mem_be_w_o};
    exp = {2'b01, 4'b1111};
    checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_req1: got %h exp %h", obs, exp); end
    m_if.mem_gnt_w_i_h = 1'b1;
    tick();
    m_if.mem_gnt_w_i_h = 1'b0;
    checks++; if (req_ready_w_o_h !== 1'b0) begin errors++; $display("FAIL b2b_wait_ready: got %b exp 0", req_ready_w_o_h); end
    m_if.mem_rvalid_w_i_h = 1'b1; m_if.mem_rdata_w_i = 32'hDEAD_BEEF;
    tick();
    m_if.mem_rvalid_w_i_h = 1'b0;
    obs = {resp_valid_w_o_h, req_ready_w_o_h, resp_rd_w_o, resp_data_w_o};
    exp = {2'b10, 5'd1, 32'hDEAD_BEEF};
    checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_resp1: got %h exp %h", obs, exp); end
    tick();
    obs = {resp_valid_w_o_h, req_ready_w_o_h, m_if.mem_req_w_o_h};
    exp = 3'b010;
    checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_gap: got %h exp %h", obs, exp); end
    tick();
    req_valid_w_i_h = 1'b0;
    obs = {req_ready_w_o_h, m_if.mem_req_w_o_h, m_if.mem_be_w_o, m_if.mem_addr_w_o};
    exp = {2'b01, 4'b0010, 32'h0100};
    checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_req2: got %h exp %h", obs, exp); end
    m_if.mem_gnt_w_i_h = 1'b1;
    tick();
    m_if.mem_gnt_w_i_h = 1'b0; m_if.mem_rvalid_w_i_h = 1'b1;
    tick();
    m_if.mem_rvalid_w_i_h = 1'b0;
    obs = {resp_valid_w_o_h, resp_rd_w_o, resp_data_w_o};
    exp = {1'b1, 5'd2, 32'h0000_00BE};
    checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_resp2: got %h exp %h", obs, exp); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_op(1'b1, F3_W, 32'h0040, 32'h0, 5'd4);
    tick();
    req_valid_w_i_h = 1'b0;
    m_if.mem_gnt_w_i_h = 1'b1;
    tick();
    m_if.mem_gnt_w_i_h = 1'b0;
    checks++; if (busy_w_o_h !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b exp 1", busy_w_o_h); end
    rst_w_i_l = 1'b0;
    #1;
    obs = {req_ready_w_o_h, busy_w_o_h, m_if.mem_req_w_o_h, resp_valid_w_o_h};
    exp = 4'b1000;
    checks++; if (obs !== exp) begin errors++; $display("FAIL rstmid_async: got %h exp %h", obs, exp); end
    m_if.mem_rvalid_w_i_h = 1'b1; m_if.mem_rdata_w_i = 32'h1111_2222;
    tick();
    rst_w_i_l = 1'b1;
    tick();
    tick();
    m_if.mem_rvalid_w_i_h = 1'b0;
    obs = {req_ready_w_o_h, busy_w_o_h, m_if.mem_req_w_o_h, resp_valid_w_o_h};
    exp = 4'b1000;
    checks++; if (obs !== exp) begin errors++; $display("FAIL rstmid_late_rvalid: got %h exp %h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_align();
    test_lb();
    test_lhu();
    test_stray();
    test_sb_stall();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the RV32 execute/memory boundary, directly downstream of the ALU.
- Takes the ALU result as the effective address, plus store data, funct3 and destination register from execute.
- Drives a single-outstanding req/gnt/rvalid data-memory port.
- Returns a one-cycle response carrying the aligned, sign/zero-extended load data, or a misalignment error.

Parameters:
- ADDR_W, 32, effective/memory address width.
- DATA_W, 32, data width (RV32 only; other values unsupported).

Ports:
- clk_w_i  input  1  clock; all state updates on the rising edge.
- rst_w_i_l  input  1  asynchronous, active-low reset.
- req_valid_w_i_h  input  1  execute presents a memory op.
- req_ready_w_o_h  output  1  LSU can accept an op.
- load_w_i_h  input  1  1 = load, 0 = store.
- funct3_w_i  input  3  RV32 width/sign field.
- addr_w_i  input  32  effective address (ALU result).
- store_data_w_i  input  32  rs2 value.
- rd_w_i  input  5  destination register tag.
- mem_req_w_o_h  output  1  memory request.
- mem_we_w_o_h  output  1  write enable.
- mem_addr_w_o  output  32  word-aligned address.
- mem_be_w_o  output  4  byte enables.
- mem_wdata_w_o  output  32  lane-replicated write data.
- mem_gnt_w_i_h  input  1  request accepted.
- mem_rvalid_w_i_h  input  1  read data valid.
- mem_rdata_w_i  input  32  read word.
- resp_valid_w_o_h  output  1  one-cycle completion pulse.
- resp_data_w_o  output  32  extended load data (0 for stores/errors).
- resp_rd_w_o  output  5  tag of the completed op.
- resp_err_w_o_h  output  1  misaligned or illegal funct3.
- busy_w_o_h  output  1  op in flight (not IDLE).

Behaviour:
- Reset: FSM to IDLE. All outputs 0 except req_ready_w_o_h = 1. Reset mid-operation abandons the op with no response; a late gnt/rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered.
  - IDLE: req_ready = 1. On req_valid, capture addr, funct3, load, data and rd.
    - Legal op goes to REQ.
    - Illegal op goes to RESP with err = 1 and no memory access.
  - REQ: mem_req = 1 and address/be/wdata/we held stable until mem_gnt.
    - On gnt, a load goes to WAIT; a store goes to RESP.
  - WAIT: on mem_rvalid, latch the extended data and go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Consequences of the FSM: req_ready = 0 outside IDLE, and only one op is ever outstanding.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal (err).
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 00. Otherwise err.
- mem_addr = {addr[31:2], 2'b00}.
- Store byte enables and data:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 4'b0011 << addr[1:0]; wdata = half replicated x2.
  - SW: be = 4'b1111; wdata = data.
- Loads drive mem_we = 0 and mem_be per the same table.
- Load extraction: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Latency:
  - Accept at cycle T, mem_req from T+1.
  - Zero-wait memory (gnt at T+1, rvalid at T+2): load resp_valid at T+3; store resp_valid at T+2.
  - Error resp_valid at T+1.
- Stray signals: gnt outside REQ and rvalid outside WAIT are ignored.
- resp_data, resp_rd and resp_err are meaningful only while resp_valid = 1 and are held otherwise.

Decomposition:
- Shared package (lsu_pkg) holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encodings.
  - Byte-enable base constants.
- One natural combinational sub-module: lsu_load_align, taking (rdata, addr[1:0], funct3) and producing the 32-bit extended result. It is reused by the bench's reference model.

Test Plan:
- LB at addr 0x1003, rdata 0x80FF_1234 -> mem_addr 0x1000, be 1000, resp_data 0xFFFF_FF80, resp_valid at T+3 with zero-wait memory.
- LHU at addr 0x2002, rdata 0xBEEF_0000 -> resp_data 0x0000_BEEF, err 0.
- SB data 0x1234_56AB at addr 0x0001, gnt delayed 3 cycles -> mem_wdata 0xABAB_ABAB, be 0010, req/addr stable through the stall, resp_valid 1 cycle after gnt.
- LW at 0x0002 -> no mem_req, resp_valid at T+1, err 1, resp_data 0. funct3 = 011 load -> same error result.
- Back-to-back req_valid held high during a load -> second op accepted only after RESP (req_ready low through REQ/WAIT/RESP), tags returned in order.
- rst_w_i_l low while in WAIT, then rvalid arrives -> IDLE immediately, no resp_valid, req_ready = 1 after reset release.
